radix2_sdf_bfly: RTL and testbench

- Radix-2 single-path delay-feedback (SDF) butterfly stage for the FFT accelerator.
- Consumer end of the twiddle interface: takes the twiddle generator's state, w_r and w_i, plus a serial complex sample stream.
- Produces butterfly sums in state 1, and twiddle-multiplied differences in state 2.
- Fixed-point format: 24-bit signed, 8 fractional bits (1.0 = 0x000100).

---
 rtl/radix2_sdf_bfly_if.sv | 26 ++
 rtl/radix2_sdf_bfly.sv | 132 +++++++++++++
 tb/tb_radix2_sdf_bfly.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/radix2_sdf_bfly_if.sv
// Sample/twiddle stream into a radix-2 SDF butterfly stage and its result stream out.
// The slave modport is the butterfly; the master modport is whatever feeds it.
interface radix2_sdf_bfly_if #(
  parameter int DW = 24
);
  logic                 in_valid;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic [1:0]           state;
  logic signed [DW-1:0] w_r;
  logic signed [DW-1:0] w_i;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;
  logic                 out_valid;
  logic                 proto_err;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  dout_r, dout_i, out_valid, proto_err
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output dout_r, dout_i, out_valid, proto_err
  );
endinterface

// File: rtl/radix2_sdf_bfly.sv
// Radix-2 single-path delay-feedback butterfly stage, Q.8 fixed point, 1-cycle latency.
// Build option SDF_ROUND_EN: round half toward +inf on the twiddle product instead of floor.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   0     | fill: push din into the delay line, no output
//   1     | butterfly: output x_d + din, push x_d - din
//   2     | twiddle-out: output x_d * W, push din (next block's first half)
//   3     | reserved: no-op, flags proto_err
module radix2_sdf_bfly #(
  parameter int DEPTH = 4,
  parameter int DW    = 24
) (
  input logic              clk,
  input logic              reset_n,
  radix2_sdf_bfly_if.slave bus
);

  localparam int PW = 2 * DW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;
  localparam logic [1:0] ST_RSVD = 2'd3;

`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(128);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic signed [DW-1:0] dl_r [DEPTH];
  logic signed [DW-1:0] dl_i [DEPTH];
  logic [CW-1:0]        fill_cnt;
  logic                 fill_full;

  logic signed [DW-1:0] dout_r_q, dout_i_q;
  logic                 out_valid_q, proto_err_q;

  logic signed [DW-1:0] x_d_r, x_d_i;
  logic signed [DW-1:0] sum_r, sum_i, diff_r, diff_i;
  logic signed [PW-1:0] xr_w, xi_w, wr_w, wi_w, pr_full, pi_full;
  logic signed [DW-1:0] prod_r, prod_i;
  logic signed [DW-1:0] push_r, push_i;
  logic                 shift_en;
  logic                 early_bfly;

  assign x_d_r     = dl_r[DEPTH-1];
  assign x_d_i     = dl_i[DEPTH-1];
  assign fill_full = (fill_cnt == CW'(DEPTH));

  always_comb begin
    sum_r  = x_d_r + bus.din_r;
    sum_i  = x_d_i + bus.din_i;
    diff_r = x_d_r - bus.din_r;
    diff_i = x_d_i - bus.din_i;

    // Operands widened first so the products and sums are exact before the shift.
    xr_w    = PW'(x_d_r);
    xi_w    = PW'(x_d_i);
    wr_w    = PW'(bus.w_r);
    wi_w    = PW'(bus.w_i);
    pr_full = xr_w * wr_w - xi_w * wi_w + RND;
    pi_full = xr_w * wi_w + xi_w * wr_w + RND;
    prod_r  = DW'(pr_full >>> 8);
    prod_i  = DW'(pi_full >>> 8);

    shift_en   = bus.in_valid && (bus.state != ST_RSVD);
    early_bfly = bus.in_valid && !fill_full &&
                 ((bus.state == ST_BFLY) || (bus.state == ST_TWID));

    push_r = bus.din_r;
    push_i = bus.din_i;
    if (bus.state == ST_BFLY) begin
      push_r = diff_r;
      push_i = diff_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
      fill_cnt    <= '0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;

      if (shift_en) begin
        dl_r[0] <= push_r;
        dl_i[0] <= push_i;
        for (int k = 1; k < DEPTH; k++) begin
          dl_r[k] <= dl_r[k-1];
          dl_i[k] <= dl_i[k-1];
        end
        if (!fill_full) fill_cnt <= fill_cnt + 1'b1;
      end

      if (bus.in_valid) begin
        case (bus.state)
          ST_BFLY: begin
            dout_r_q    <= sum_r;
            dout_i_q    <= sum_i;
            out_valid_q <= 1'b1;
          end
          ST_TWID: begin
            dout_r_q    <= prod_r;
            dout_i_q    <= prod_i;
            out_valid_q <= 1'b1;
          end
          ST_RSVD: proto_err_q <= 1'b1;
          ST_FILL: ;
          default: ;
        endcase
      end

      if (early_bfly) proto_err_q <= 1'b1;
    end
  end

  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;
  assign bus.out_valid = out_valid_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_radix2_sdf_bfly.sv
// Directed bench for radix2_sdf_bfly (DEPTH=4, DW=24); expected values are hand-computed.
// Rounding expectations follow SDF_ROUND_EN when the bench is built with it.
module tb_radix2_sdf_bfly;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  radix2_sdf_bfly_if #(.DW(24)) bus ();

  radix2_sdf_bfly #(.DEPTH(4), .DW(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%06h expected 0x%06h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] er, input logic [23:0] ei,
                         input logic ev);
    chk({tag, ".r"}, {8'h0, bus.dout_r}, {8'h0, er});
    chk({tag, ".i"}, {8'h0, bus.dout_i}, {8'h0, ei});
    chk({tag, ".ov"}, {31'h0, bus.out_valid}, {31'h0, ev});
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [1:0] st, input logic [23:0] dr,
                       input logic [23:0] di, input logic [23:0] wr, input logic [23:0] wi);
    @(negedge clk);
    bus.in_valid = v;
    bus.state    = st;
    bus.din_r    = dr;
    bus.din_i    = di;
    bus.w_r      = wr;
    bus.w_i      = wi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk_out("reset", 24'h0, 24'h0, 1'b0);
    chk("reset.err", {31'h0, bus.proto_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_const(input string tag);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd0, 24'h000100, 24'h0, 24'h0, 24'h0);
      chk({tag, ".fill.ov"}, {31'h0, bus.out_valid}, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd1, 24'h000100, 24'h0, 24'h0, 24'h0);
      chk_out({tag, ".bfly"}, 24'h000200, 24'h0, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000100, 24'h0);
      chk_out({tag, ".twid"}, 24'h0, 24'h0, 1'b1);
    end
    chk({tag, ".err"}, {31'h0, bus.proto_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] rnd_r;
    bus.in_valid = 1'b0;
    bus.state    = 2'd0;
    bus.din_r    = '0;
    bus.din_i    = '0;
    bus.w_r      = '0;
    bus.w_i      = '0;

    #1;
    chk_out("por", 24'h0, 24'h0, 1'b0);
    chk("por.err", {31'h0, bus.proto_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_const("const");

    // Twiddle products on stored differences of 0x100
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 2'd0, 24'h000100, 24'h0, 24'h0, 24'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd1, 24'h0, 24'h0, 24'h0, 24'h0);
      chk_out("tw.bfly", 24'h000100, 24'h0, 1'b1);
    end
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000100, 24'h000000);
    chk_out("tw.w0", 24'h000100, 24'h000000, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h0000B5, 24'hFFFF4B);
    chk_out("tw.w1", 24'h0000B5, 24'hFFFF4B, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000000, 24'hFFFF00);
    chk_out("tw.w2", 24'h000000, 24'hFFFF00, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'hFFFF4B, 24'hFFFF4B);
    chk_out("tw.w3", 24'hFFFF4B, 24'hFFFF4B, 1'b1);
    chk("tw.err", {31'h0, bus.proto_err}, 32'h0);

    // Rounding on a stored difference of 1+0j
`ifdef SDF_ROUND_EN
    rnd_r = 24'h000001;
`else
    rnd_r = 24'h000000;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 2'd0, 24'h000001, 24'h0, 24'h0, 24'h0);
    for (int k = 0; k < 4; k++) drive(1'b1, 2'd1, 24'h0, 24'h0, 24'h0, 24'h0);
    chk_out("rnd.bfly", 24'h000001, 24'h0, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h0000B5, 24'hFFFF4B);
    chk_out("rnd.twid", rnd_r, 24'hFFFFFF, 1'b1);

    // Stall mid-butterfly with distinct samples
    do_reset();
    drive(1'b1, 2'd0, 24'h000100, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 2'd0, 24'h000200, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 2'd0, 24'h000300, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 2'd0, 24'h000400, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 2'd1, 24'h000010, 24'h0, 24'h0, 24'h0);
    chk_out("stall.b0", 24'h000110, 24'h0, 1'b1);
    drive(1'b1, 2'd1, 24'h000020, 24'h0, 24'h0, 24'h0);
    chk_out("stall.b1", 24'h000220, 24'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'd1, 24'h000777, 24'h000777, 24'h0, 24'h0);
      chk_out("stall.idle", 24'h000220, 24'h0, 1'b0);
    end
    drive(1'b1, 2'd1, 24'h000030, 24'h0, 24'h0, 24'h0);
    chk_out("stall.b2", 24'h000330, 24'h0, 1'b1);
    drive(1'b1, 2'd1, 24'h000040, 24'h0, 24'h0, 24'h0);
    chk_out("stall.b3", 24'h000440, 24'h0, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000100, 24'h0);
    chk_out("stall.t0", 24'h0000F0, 24'h0, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000100, 24'h0);
    chk_out("stall.t1", 24'h0001E0, 24'h0, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000100, 24'h0);
    chk_out("stall.t2", 24'h0002D0, 24'h0, 1'b1);
    drive(1'b1, 2'd2, 24'h0, 24'h0, 24'h000100, 24'h0);
    chk_out("stall.t3", 24'h0003C0, 24'h0, 1'b1);

    // Butterfly before the delay line is full
    do_reset();
    drive(1'b1, 2'd1, 24'h000100, 24'h0, 24'h0, 24'h0);
    chk_out("perr.early", 24'h000100, 24'h0, 1'b1);
    chk("perr.early.err", {31'h0, bus.proto_err}, 32'h1);
    drive(1'b0, 2'd0, 24'h0, 24'h0, 24'h0, 24'h0);
    drive(1'b0, 2'd0, 24'h0, 24'h0, 24'h0, 24'h0);
    chk("perr.sticky", {31'h0, bus.proto_err}, 32'h1);

    // Reserved state: flagged, no output, no shift
    do_reset();
    drive(1'b1, 2'd3, 24'h000999, 24'h000999, 24'h0, 24'h0);
    chk("perr.rsvd.err", {31'h0, bus.proto_err}, 32'h1);
    chk("perr.rsvd.ov", {31'h0, bus.out_valid}, 32'h0);
    for (int k = 0; k < 4; k++) drive(1'b1, 2'd0, 24'h000100, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 2'd1, 24'h0, 24'h0, 24'h0, 24'h0);
    chk_out("perr.rsvd.noshift", 24'h000100, 24'h0, 1'b1);
    chk("perr.rsvd.sticky", {31'h0, bus.proto_err}, 32'h1);

    // Reset during the second butterfly sample
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 2'd0, 24'h000100, 24'h0, 24'h0, 24'h0);
    drive(1'b1, 2'd1, 24'h000100, 24'h0, 24'h0, 24'h0);
    chk_out("midrst.b0", 24'h000200, 24'h0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.state    = 2'd1;
    bus.din_r    = 24'h000100;
    bus.din_i    = 24'h0;
    reset_n      = 1'b0;
    #1;
    chk_out("midrst.async", 24'h0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("midrst.held", 24'h0, 24'h0, 1'b0);
    chk("midrst.err", {31'h0, bus.proto_err}, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    run_const("rerun");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
